// File: rtl/sap_reg_bank.sv
// sap_reg_bank: multi-entry register bank for the SAP datapath.
// Each write applies one operation (load/inc/dec/shl/shr/clr) to a single entry
// and updates the registered zero/carry flags. There are two combinational read ports.
module sap_reg_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  inputData,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  outputDataA,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  outputDataB,
    output logic              zero,
    output logic              carry
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             hit;
    logic             upd;

    // Fetch the entry addressed by waddr; an address past NUM_REGS leaves hit low.
    always_comb begin
        old_val = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (waddr == ADDR_W'(i)) begin
                old_val = regs_q[i];
                hit     = 1'b1;
            end
        end
    end

    // Compute the op result and its carry. HOLD and the reserved code leave upd low.
    always_comb begin
        res   = old_val;
        res_c = 1'b0;
        upd   = 1'b1;
        case (op)
            OP_LOAD: res = inputData;
            OP_INC: begin
                res   = old_val + WIDTH'(1);
                res_c = &old_val;
            end
            OP_DEC: begin
                res   = old_val - WIDTH'(1);
                res_c = (old_val == '0);
            end
            OP_SHL: begin
                res   = {old_val[WIDTH-2:0], 1'b0};
                res_c = old_val[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, old_val[WIDTH-1:1]};
                res_c = old_val[0];
            end
            OP_CLR:  res = '0;
            OP_HOLD: upd = 1'b0;
            default: upd = 1'b0;
        endcase
    end

    // Next state: write the result and flags only for a valid in-range op.
    always_comb begin
        regs_d  = regs_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (we && hit && upd) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = res;
                end
            end
            zero_d  = (res == '0);
            carry_d = res_c;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Read ports: no write bypass. An out-of-range address reads as zero.
    always_comb begin
        outputDataA = '0;
        outputDataB = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (raddr_a == ADDR_W'(i)) outputDataA = regs_q[i];
            if (raddr_b == ADDR_W'(i)) outputDataB = regs_q[i];
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: doc/sap_reg_bank.md
Name: sap_reg_bank

Overview:
- Parametrised multi-entry general-purpose register bank for the SAP datapath.
- Generalises the single enable-loaded operand register in three ways:
  - NUM_REGS entries of WIDTH bits.
  - Per-write operation select: load, increment, decrement, shift left, shift right, clear.
  - Registered zero/carry flags for the control sequencer.
- Two combinational read ports feed the ALU operands and the output register.

Parameters:
- WIDTH, 8: data width of every entry and of the data ports.
- NUM_REGS, 4: number of entries; must be 2 or more.
- ADDR_W, 2: address width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  main clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable; when 1, op is applied to entry waddr this cycle.
- waddr  input  ADDR_W  target entry for the write/op.
- op  input  3  operation select (encoding under Behaviour).
- inputData  input  WIDTH  load data for LOAD.
- raddr_a  input  ADDR_W  read address, port A.
- outputDataA  output  WIDTH  contents of entry raddr_a (combinational).
- raddr_b  input  ADDR_W  read address, port B.
- outputDataB  output  WIDTH  contents of entry raddr_b (combinational).
- zero  output  1  registered: result of the last flag-updating op was 0.
- carry  output  1  registered: carry/borrow/shifted-out bit of the last flag-updating op.

Behaviour:
- Reset:
  - Sampled only on a rising clk edge with rst_n=0. Asynchronous rst_n edges have no effect.
  - On reset: every entry becomes 0, zero=0, carry=0.
  - Reset overrides we in the same cycle.
- Op encoding; result R is the value written to entry waddr at the edge:
  - 000 HOLD: no change.
  - 001 LOAD: R=inputData, carry=0.
  - 010 INC: R=old+1 mod 2^WIDTH, carry=1 iff old was all-ones.
  - 011 DEC: R=old-1 mod 2^WIDTH, carry=1 iff old was 0 (borrow).
  - 100 SHL: R={old[WIDTH-2:0],0}, carry=old[WIDTH-1].
  - 101 SHR: R={0,old[WIDTH-1:1]}, carry=old[0].
  - 110 CLR: R=0, carry=0.
  - 111 reserved: treated as HOLD.
- Flags:
  - Updated only when we=1, waddr < NUM_REGS and op is 001..110.
  - zero <= (R==0); carry as listed per op.
  - Otherwise both flags hold their value.
- Write latency:
  - The new value is visible on the read ports immediately after the edge (1-cycle write latency).
  - No write-to-read bypass: a read of waddr in the write cycle returns the old value.
- Out-of-range write (waddr >= NUM_REGS): the write is ignored, no entry changes, flags hold.
- Out-of-range read (raddr >= NUM_REGS): the port outputs 0.
- Each edge performs at most one write. The two read ports are independent and may read the same entry, including the entry being written.
- we=0: all entries and flags hold, regardless of op and waddr.
- Reset mid-sequence: state is cleared on the reset edge. The first op after rst_n returns to 1 acts on the zeroed bank.

Test Plan:
- Reset and load: hold rst_n=0 for 2 edges, then release. Then LOAD 0xA5 into r1 and 0x3C into r2; set raddr_a=1, raddr_b=2.
  - Before the loads: all reads give 0; zero=0, carry=0.
  - After the loads: outputDataA=0xA5, outputDataB=0x3C, zero=0, carry=0.
- Wrap-around: LOAD 0xFF into r0, then INC r0 -> r0=0x00, zero=1, carry=1. Then DEC r0 -> r0=0xFF, zero=0, carry=1 (borrow). Then DEC r0 -> 0xFE, carry=0.
- Shifts: LOAD 0x81 into r3. SHL -> 0x02, carry=1. SHR -> 0x01, carry=0. SHR -> 0x00, carry=1, zero=1.
- Hold/disable cases, all from a known state:
  - we=0 with op=CLR: no change.
  - op=111 with we=1: no change, flags hold.
  - we=1, op=LOAD, waddr=1, inputData=0x77, raddr_a=1 in the same cycle: outputDataA shows the old value during the cycle and 0x77 after the edge.
- Parameter sweep: WIDTH=16, NUM_REGS=3, ADDR_W=2.
  - LOAD 0x1234 to waddr=3 (out of range): ignored, flags unchanged.
  - raddr_a=3 -> outputDataA=0x0000.
  - INC of 0xFFFF in r2 -> 0x0000, carry=1.
- Synchronous reset check:
  - Drop rst_n between edges: state unchanged until the next rising edge, then all entries 0 and both flags 0.
  - Assert rst_n=0 together with we=1, op=LOAD: reset wins.
